// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared constants and types for the MAX7219 scan controller
package max7219_pkg;

   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCANLIM   = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_TEST      = 4'hF;

   typedef logic [15:0] frame_t;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_REFRESH
   } ctrl_state_t;

   // Wire format of one MAX7219 write: upper nibble is don't-care, sent as zero.
   function automatic frame_t mk_frame(input logic [3:0] addr, input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

endpackage

// File: rtl/max7219_scan_ctrl_if.sv
// rtl/max7219_scan_ctrl_if.sv - application-side request/status bundle
interface max7219_scan_ctrl_if;
   logic [31:0] num;
   logic [7:0]  dp;
   logic        update;
   logic        busy;

   modport master (output num, output dp, output update, input busy);
   modport slave  (input num, input dp, input update, output busy);
endinterface

// File: rtl/max7219_spi_tx.sv
// rtl/max7219_spi_tx.sv - 16-bit frame shifter with SCLK divider and inter-frame gap
module max7219_spi_tx
   import max7219_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   start,
   input  frame_t frame,
   output logic   ready,
   output logic   spi_sclk,
   output logic   spi_mosi,
   output logic   spi_cs_n
);

   // One counter serves both the half-period divider and the 2*CLK_DIV gap.
   localparam int CNT_W = $clog2(2 * CLK_DIV);
   localparam int BIT_W = $clog2(16);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(15);

   logic             active_q;
   logic             gap_q;
   logic [CNT_W-1:0] cnt_q;
   logic [BIT_W-1:0] bit_q;
   logic [14:0]      shift_q;
   logic             sclk_q;
   logic             mosi_q;
   logic             cs_n_q;

   // Ready in the last gap cycle so the next frame's CS falls exactly 2*CLK_DIV after the previous rise.
   assign ready    = !active_q && (!gap_q || (cnt_q == GAP_LAST));
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;

   // Frame shifting: SCLK toggles every CLK_DIV cycles, data advances on falling edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         gap_q    <= 1'b0;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_n_q   <= 1'b1;
      end else if (active_q) begin
         if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (!sclk_q) begin
               sclk_q <= 1'b1;
            end else begin
               sclk_q <= 1'b0;
               if (bit_q == BIT_LAST) begin
                  active_q <= 1'b0;
                  gap_q    <= 1'b1;
                  cs_n_q   <= 1'b1;
                  mosi_q   <= 1'b0;
                  bit_q    <= '0;
               end else begin
                  bit_q   <= bit_q + BIT_W'(1);
                  mosi_q  <= shift_q[14];
                  shift_q <= {shift_q[13:0], 1'b0};
               end
            end
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         if (gap_q) begin
            if (cnt_q == GAP_LAST) begin
               gap_q <= 1'b0;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (start && ready) begin
            active_q <= 1'b1;
            cs_n_q   <= 1'b0;
            mosi_q   <= frame[15];
            shift_q  <= frame[14:0];
            bit_q    <= '0;
            cnt_q    <= '0;
         end
      end
   end

endmodule

// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - hex nibble to active-low seven-segment pattern (GFEDCBA)
module sseg_decoder (
   input  logic [3:0] x,
   output logic [6:0] y
);

   // y[0] is segment A, y[6] is segment G; a 0 lights the segment.
   always_comb begin
      case (x)
         4'h0:    y = 7'h40;
         4'h1:    y = 7'h79;
         4'h2:    y = 7'h24;
         4'h3:    y = 7'h30;
         4'h4:    y = 7'h19;
         4'h5:    y = 7'h12;
         4'h6:    y = 7'h02;
         4'h7:    y = 7'h78;
         4'h8:    y = 7'h00;
         4'h9:    y = 7'h10;
         4'hA:    y = 7'h08;
         4'hB:    y = 7'h03;
         4'hC:    y = 7'h46;
         4'hD:    y = 7'h21;
         4'hE:    y = 7'h06;
         default: y = 7'h0E;
      endcase
   end

endmodule

// File: rtl/max7219_scan_ctrl.sv
// rtl/max7219_scan_ctrl.sv - MAX7219 init and eight-digit refresh sequencer
module max7219_scan_ctrl
   import max7219_pkg::*;
#(
   parameter int         CLK_DIV   = 4,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   max7219_scan_ctrl_if.slave         app,
   output logic                       spi_sclk,
   output logic                       spi_mosi,
   output logic                       spi_cs_n
);

   ctrl_state_t state_q, state_d;
   logic [2:0]  idx_q;
   logic        last_q;
   logic        pending_q;
   logic [31:0] num_q;
   logic [7:0]  dp_q;

   logic        tx_ready;
   logic        tx_start;
   frame_t      tx_frame;
   logic [6:0]  seg_y;
   logic [2:0]  last_idx;
   logic        seq_done;
   logic        take_snap;

   // Sequence ends once the final frame has been issued and its gap has elapsed.
   assign last_idx  = (state_q == ST_INIT) ? 3'd4 : 3'd7;
   assign seq_done  = (state_q != ST_IDLE) && last_q && tx_ready;
   assign take_snap = ((state_q == ST_IDLE) && app.update) ||
                      (seq_done && (pending_q || app.update));

   sseg_decoder u_dec (
      .x (num_q[{idx_q, 2'b00} +: 4]),
      .y (seg_y)
   );

   max7219_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (tx_start),
      .frame    (tx_frame),
      .ready    (tx_ready),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   // Next state: a pending request chains straight into another refresh.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT, ST_REFRESH: begin
            if (seq_done) state_d = (pending_q || app.update) ? ST_REFRESH : ST_IDLE;
         end
         ST_IDLE: begin
            if (app.update) state_d = ST_REFRESH;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Frame index, pending request and the display snapshot held for a whole pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         last_q    <= 1'b0;
         pending_q <= 1'b0;
         num_q     <= '0;
         dp_q      <= '0;
      end else if (take_snap) begin
         num_q     <= app.num;
         dp_q      <= app.dp;
         idx_q     <= '0;
         last_q    <= 1'b0;
         pending_q <= 1'b0;
      end else if (seq_done) begin
         idx_q  <= '0;
         last_q <= 1'b0;
      end else begin
         if (app.update && (state_q != ST_IDLE)) pending_q <= 1'b1;
         if (tx_start) begin
            if (idx_q == last_idx) last_q <= 1'b1;
            else                   idx_q  <= idx_q + 3'd1;
         end
      end
   end

   // Outputs: busy, frame issue and the frame contents for the current index.
   always_comb begin
      app.busy = (state_q != ST_IDLE);
      tx_start = (state_q != ST_IDLE) && !last_q && tx_ready;
      tx_frame = mk_frame(REG_TEST, 8'h00);
      if (state_q == ST_INIT) begin
         case (idx_q)
            3'd0:    tx_frame = mk_frame(REG_SHUTDOWN,  8'h01);
            3'd1:    tx_frame = mk_frame(REG_DECODE,    8'h00);
            3'd2:    tx_frame = mk_frame(REG_SCANLIM,   8'h07);
            3'd3:    tx_frame = mk_frame(REG_INTENSITY, {4'h0, INTENSITY});
            default: tx_frame = mk_frame(REG_TEST,      8'h00);
         endcase
      end else begin
         tx_frame = mk_frame(REG_DIGIT0 + {1'b0, idx_q},
                             {dp_q[idx_q], ~seg_y[0], ~seg_y[1], ~seg_y[2],
                              ~seg_y[3], ~seg_y[4], ~seg_y[5], ~seg_y[6]});
      end
   end

endmodule

// File: tb/tb_max7219_scan_ctrl.sv
// tb/tb_max7219_scan_ctrl.sv - randomized self-checking bench for max7219_scan_ctrl
module tb_max7219_scan_ctrl;

   localparam int D      = 2;
   localparam int M_INIT = 0;
   localparam int M_REF  = 1;
   localparam int M_IDLE = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic spi_sclk, spi_mosi, spi_cs_n;

   max7219_scan_ctrl_if app_if ();

   max7219_scan_ctrl #(.CLK_DIV(D), .INTENSITY(4'h8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .app      (app_if.slave),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n)
   );

   always #5 clk = ~clk;

   int errors  = 0;
   int checks  = 0;
   int tmo_req = 0;
   int tmo_ack = 0;
   int nfr     = 0;

   // ABCDEFG (A in bit 6), active high, as a person would draw the hex digit.
   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
         4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
         4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
         4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
      endcase
   endfunction

   function automatic logic [15:0] init_frame(input int i);
      case (i)
         0: return 16'h0C01;
         1: return 16'h0900;
         2: return 16'h0B07;
         3: return 16'h0A08;
         default: return 16'h0F00;
      endcase
   endfunction

   function automatic logic [15:0] exp_frame(input int mode, input int idx,
                                             input logic [31:0] n, input logic [7:0] p);
      logic [3:0] nib;
      if (mode == M_INIT) return init_frame(idx);
      nib = 4'((n >> (4 * idx)) & 32'hF);
      return {4'h0, 4'(idx + 1), p[idx], seg7(nib)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   int          cyc = 0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b1;
   int          m_mode = M_INIT, m_idx = 0;
   bit          m_pend = 1'b0;
   logic [31:0] m_num = '0;
   logic [7:0]  m_dp = '0;
   logic [15:0] sh = '0;
   logic [15:0] ef;
   int          nb = 0, low_start = 0, high_start = 0, upd_cyc = -1;

   // Single compare process: behavioural model of frames, timing and busy, checked every cycle.
   always @(negedge clk) begin
      cyc++;
      if (tmo_req != tmo_ack) begin
         check("wait_bound", tmo_req, tmo_ack);
         tmo_ack = tmo_req;
      end
      if (!rst_n) begin
         check("rst_cs_n", spi_cs_n, 1);
         check("rst_sclk", spi_sclk, 0);
         check("rst_mosi", spi_mosi, 0);
         check("rst_busy", app_if.busy, 1);
         m_mode = M_INIT; m_idx = 0; m_pend = 1'b0; nb = 0; upd_cyc = -1;
         prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b1;
      end else begin
         if (app_if.update) begin
            if (m_mode == M_IDLE) begin
               m_mode = M_REF; m_idx = 0; m_num = app_if.num; m_dp = app_if.dp; upd_cyc = cyc;
            end else begin
               m_pend = 1'b1;
            end
         end
         if (upd_cyc >= 0 && cyc == upd_cyc + 1) check("busy_rise", app_if.busy, 1);
         if (spi_cs_n) check("sclk_idle", spi_sclk, 0);
         if (prev_cs && !spi_cs_n) begin
            check("frame_while_idle", (m_mode != M_IDLE), 1);
            if (m_mode != M_IDLE) begin
               ef = exp_frame(m_mode, m_idx, m_num, m_dp);
               check("mosi_bit15", spi_mosi, ef[15]);
               if (m_idx > 0) check("gap_len", cyc - high_start, 2 * D);
               if (upd_cyc >= 0) begin
                  check("upd_to_cs", cyc - upd_cyc, 2);
                  upd_cyc = -1;
               end
            end
            nb = 0; sh = '0; low_start = cyc;
         end
         if (!spi_cs_n && spi_sclk && !prev_sclk) begin
            sh = {sh[14:0], spi_mosi};
            nb++;
         end
         if (!prev_cs && spi_cs_n) begin
            high_start = cyc;
            check("bit_count", nb, 16);
            check("cs_low_len", cyc - low_start, 32 * D);
            if (m_mode != M_IDLE) begin
               ef = exp_frame(m_mode, m_idx, m_num, m_dp);
               check("frame", sh, ef);
               case (nfr)
                  0:  check("lit_f0",  sh, 16'h0C01);
                  1:  check("lit_f1",  sh, 16'h0900);
                  2:  check("lit_f2",  sh, 16'h0B07);
                  3:  check("lit_f3",  sh, 16'h0A08);
                  4:  check("lit_f4",  sh, 16'h0F00);
                  5:  check("lit_f5",  sh, 16'h0130);
                  6:  check("lit_f6",  sh, 16'h027E);
                  12: check("lit_f12", sh, 16'h087E);
                  13: check("lit_f13", sh, 16'h017E);
                  20: check("lit_f20", sh, 16'h08FF);
                  29: check("lit_f29", sh, 16'h01ED);
                  36: check("lit_f36", sh, 16'h08CE);
                  default: ;
               endcase
               nfr++;
               m_idx++;
               if ((m_mode == M_INIT && m_idx == 5) || (m_mode == M_REF && m_idx == 8)) begin
                  if (m_pend) begin
                     m_mode = M_REF; m_idx = 0; m_num = app_if.num; m_dp = app_if.dp; m_pend = 1'b0;
                  end else begin
                     m_mode = M_IDLE;
                  end
               end
            end
         end
         if (prev_busy && !app_if.busy) begin
            check("busy_fall_mode", m_mode, M_IDLE);
            check("busy_fall_time", cyc - high_start, 2 * D);
         end
         prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_busy = app_if.busy;
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(posedge clk); #1;
      while (app_if.busy && n < 20000) begin @(posedge clk); #1; n++; end
      if (app_if.busy) tmo_req++;
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (nfr < target && n < 5000) begin @(posedge clk); #1; n++; end
      if (nfr < target) tmo_req++;
   endtask

   task automatic pulse(input logic [31:0] n, input logic [7:0] p);
      @(posedge clk); #1;
      app_if.num = n; app_if.dp = p; app_if.update = 1'b1;
      @(posedge clk); #1;
      app_if.update = 1'b0;
   endtask

   task automatic set_num(input logic [31:0] n, input logic [7:0] p);
      @(posedge clk); #1;
      app_if.num = n; app_if.dp = p;
   endtask

   initial begin
      int base, k, n;
      rst_n = 1'b0;
      app_if.num = '0; app_if.dp = '0; app_if.update = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle();

      pulse(32'h0000_0001, 8'h00);
      wait_idle();
      pulse(32'h8000_0000, 8'h80);
      wait_idle();

      pulse(32'h1234_5678, 8'h0F);
      wait_frames(23);
      pulse(32'hDEAD_BEEF, 8'h3C);
      wait_frames(24);
      pulse(32'hDEAD_BEEF, 8'h3C);
      wait_frames(25);
      pulse(32'hCAFE_0042, 8'hA5);
      wait_idle();

      for (int r = 0; r < 5; r++) begin
         base = nfr;
         pulse($urandom, 8'($urandom_range(0, 255)));
         wait_frames(base + 2);
         set_num($urandom, 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
               wait_frames(base + 3 + j);
               pulse($urandom, 8'($urandom_range(0, 255)));
            end
         end
         wait_idle();
      end

      base = nfr;
      pulse($urandom, 8'($urandom_range(0, 255)));
      wait_frames(base + 2);
      n = 0;
      while (spi_cs_n && n < 1000) begin @(posedge clk); #1; n++; end
      if (spi_cs_n) tmo_req++;
      repeat (2 * D * 7 + 1) @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle();

      pulse($urandom, 8'($urandom_range(0, 255)));
      wait_idle();

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
